// File: rtl/exe_mem_req.sv
// exe_mem_req: single-entry memory request stage between execute and memory.
// Captures one load/store, raises a request on the memory address channel and
// holds it until accepted, then presents the entry to the next stage.
// A flush arriving while a request is outstanding drains it before going idle.
// Optional feature macro: MEM_REQ_ALE_EN enables address-misalignment
// detection (out_ale, misaligned accesses are not issued).
module exe_mem_req #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  localparam int BW     = DATA_W / 8,
  localparam int LW     = $clog2(BW)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_allowin,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [1:0]        in_size,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_ex,
  input  logic              later_ex,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_allowin,
  output logic              out_ale,
  output logic              out_issued,
  output logic [LW-1:0]     out_addr_lo,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BW-1:0]     mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  state_t              entry_st_s;
  logic                mem_req_r;
  logic                out_valid_r;
  logic                ale_r;
  logic                issued_r;
  logic                in_allowin_s;
  logic                cap_s;
  logic                ale_s;
  logic                go_req_s;
  logic                req_ok_s;
  logic [1:0]          size_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                wr_r;
  logic [BW-1:0]       wstrb_r;
  logic [DATA_W-1:0]   wdata_r;

  // Byte enables: size mask shifted into the addressed lanes; loads write nothing.
  function automatic logic [BW-1:0] calc_wstrb(input logic st, input logic [1:0] sz,
                                               input logic [LW-1:0] lo);
    logic [BW-1:0] base_s;
    base_s = {BW{1'b0}};
    case (sz)
      2'd0:    base_s[0]   = 1'b1;
      2'd1:    base_s[1:0] = 2'b11;
      2'd2:    base_s[3:0] = 4'hF;
      default: base_s      = {BW{1'b1}};
    endcase
    return st ? (base_s << lo) : {BW{1'b0}};
  endfunction

  // Store data replicated across every lane the access could land in.
  function automatic logic [DATA_W-1:0] calc_wdata(input logic [1:0] sz,
                                                   input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] res_s;
    case (sz)
      2'd0:    res_s = {BW{d[7:0]}};
      2'd1:    res_s = {(BW/2){d[15:0]}};
      2'd2:    res_s = {(BW/4){d[31:0]}};
      default: res_s = d;
    endcase
    return res_s;
  endfunction

`ifdef MEM_REQ_ALE_EN
  // Misalignment by access size; a dword on a 32-bit bus is never legal.
  function automatic logic calc_ale(input logic [1:0] sz, input logic [2:0] a);
    logic res_s;
    case (sz)
      2'd0:    res_s = 1'b0;
      2'd1:    res_s = a[0];
      2'd2:    res_s = (a[1:0] != 2'b00);
      2'd3:    res_s = (DATA_W == 64) ? (a != 3'b000) : 1'b1;
      default: res_s = 1'b1;
    endcase
    return res_s;
  endfunction

  assign ale_s = calc_ale(in_size, in_addr[2:0]);
`else
  assign ale_s = 1'b0;
`endif

  assign in_allowin_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_allowin);
  assign cap_s        = in_valid && in_allowin_s && !flush;
  assign go_req_s     = (in_load || in_store) && !in_ex && !ale_s && !later_ex;
  assign entry_st_s   = go_req_s ? ST_REQ : ST_DONE;
  assign req_ok_s     = (state_r == ST_REQ) && mem_addr_ok;

  // Next-state decode; flush beats capture, an outstanding request must drain.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (flush)         state_nx_s = ST_IDLE;
        else if (in_valid) state_nx_s = entry_st_s;
        else               state_nx_s = ST_IDLE;
      end
      ST_REQ: begin
        if (mem_addr_ok) begin
          if (flush) state_nx_s = ST_IDLE;
          else       state_nx_s = ST_DONE;
        end else begin
          if (flush) state_nx_s = ST_DRAIN;
          else       state_nx_s = ST_REQ;
        end
      end
      ST_DONE: begin
        if (flush) state_nx_s = ST_IDLE;
        else if (out_allowin) begin
          if (in_valid) state_nx_s = entry_st_s;
          else          state_nx_s = ST_IDLE;
        end else        state_nx_s = ST_DONE;
      end
      ST_DRAIN: begin
        if (mem_addr_ok) state_nx_s = ST_IDLE;
        else             state_nx_s = ST_DRAIN;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Control state and flag registers; request/valid are flops decoded from next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      mem_req_r   <= 1'b0;
      out_valid_r <= 1'b0;
      ale_r       <= 1'b0;
      issued_r    <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      mem_req_r   <= (state_nx_s == ST_REQ) || (state_nx_s == ST_DRAIN);
      out_valid_r <= (state_nx_s == ST_DONE);
      if (cap_s) begin
        ale_r    <= ale_s;
        issued_r <= 1'b0;
      end else if (req_ok_s) begin
        issued_r <= 1'b1;
      end
    end
  end

  // Held request fields; loaded only on capture so they stay stable until accepted.
  always_ff @(posedge clk) begin
    if (cap_s) begin
      size_r  <= in_size;
      addr_r  <= in_addr;
      wr_r    <= in_store;
      wstrb_r <= calc_wstrb(in_store, in_size, in_addr[LW-1:0]);
      wdata_r <= calc_wdata(in_size, in_wdata);
    end
  end

  assign in_allowin  = in_allowin_s;
  assign out_valid   = out_valid_r;
  assign out_ale     = ale_r;
  assign out_issued  = issued_r;
  assign out_addr_lo = addr_r[LW-1:0];
  assign mem_req     = mem_req_r;
  assign mem_wr      = wr_r;
  assign mem_size    = size_r;
  assign mem_addr    = addr_r;
  assign mem_wstrb   = wstrb_r;
  assign mem_wdata   = wdata_r;

endmodule
